// File: rtl/spi_bit_sequencer_if.sv
// ============================================================================
// Module   : spi_bit_sequencer_if
// Brief    : Control, memory-port and serial-pin bundle for spi_bit_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_bit_sequencer_if #(
    parameter int ADDR_W = 14,
    parameter int WAIT_W = 16,
    parameter int REP_W  = 8
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] conf_size;
    logic [WAIT_W-1:0] conf_wait;
    logic [REP_W-1:0]  conf_repeat;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              wr_en;
    logic              sdi;
    logic              sdo;
    logic              sen;
    logic              sclk_en;
    logic              busy;
    logic              done;

    modport slave (
        input  start, stop, conf_size, conf_wait, conf_repeat, rd_data, sdo,
        output rd_addr, wr_addr, wr_data, wr_en, sdi, sen, sclk_en, busy, done
    );

    modport master (
        output start, stop, conf_size, conf_wait, conf_repeat, rd_data, sdo,
        input  rd_addr, wr_addr, wr_data, wr_en, sdi, sen, sclk_en, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/spi_bit_sequencer.sv
// ============================================================================
// Module   : spi_bit_sequencer
// Brief    : Walks the output-bit memory onto SDI, captures SDO into the
//            input-bit memory, with repeat count and idle gap between transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_bit_sequencer #(
    parameter int ADDR_W = 14,
    parameter int WAIT_W = 16,
    parameter int REP_W  = 8
) (
    input  wire logic           spi_clk,
    input  wire logic           rst_n,
    spi_bit_sequencer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_addr_two = (ADDR_W+1)'(2);
    localparam logic [WAIT_W-1:0] c_wait_one = WAIT_W'(1);
    localparam logic [REP_W-1:0]  c_rep_one  = REP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_size;
    logic [WAIT_W-1:0] r_wait;
    logic [REP_W-1:0]  r_repeat;
    logic [ADDR_W-1:0] r_k;
    logic [REP_W-1:0]  r_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_data;
    logic              r_wr_en;

    logic              w_last_bit;
    logic [REP_W-1:0]  w_cnt_inc;
    logic              w_rep_hit;
    logic              w_wait_over;
    logic [ADDR_W:0]   w_k_plus2;
    logic [ADDR_W-1:0] w_prefetch;

    assign w_last_bit  = (r_k == (r_size - c_addr_one));
    assign w_cnt_inc   = r_cnt + c_rep_one;
    assign w_rep_hit   = (r_repeat != '0) && (w_cnt_inc == r_repeat);
    assign w_wait_over = (r_wait_cnt == (r_wait - c_wait_one));

    // Prefetch address stays inside 0..SIZE-1; past the end it parks at 0,
    // which is exactly what a back-to-back LOAD needs.
    assign w_k_plus2  = {1'b0, r_k} + c_addr_two;
    assign w_prefetch = (w_k_plus2 < {1'b0, r_size}) ? w_k_plus2[ADDR_W-1:0] : '0;

    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.conf_size != '0) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (bus.stop || w_rep_hit) begin
                        w_state_next = ST_FINISH;
                    end else if (r_wait == '0) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.stop) begin
                    w_state_next = ST_FINISH;
                end else if (w_wait_over) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= '0;
            r_wait     <= '0;
            r_repeat   <= '0;
            r_k        <= '0;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= 1'b0;
            r_wr_en    <= 1'b0;
        end else begin
            // Capture pipeline: SDO sampled at the end of bit k is written next cycle.
            r_wr_en <= (r_state == ST_SHIFT);
            if (r_state == ST_SHIFT) begin
                r_wr_addr <= r_k;
                r_wr_data <= bus.sdo;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start && (bus.conf_size != '0)) begin
                        r_size    <= bus.conf_size;
                        r_wait    <= bus.conf_wait;
                        r_repeat  <= bus.conf_repeat;
                        r_cnt     <= '0;
                        r_rd_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    r_k       <= '0;
                    r_rd_addr <= (r_size > c_addr_one) ? c_addr_one : '0;
                end
                ST_SHIFT: begin
                    r_k       <= r_k + c_addr_one;
                    r_rd_addr <= w_prefetch;
                    if (w_last_bit) begin
                        r_cnt      <= w_cnt_inc;
                        r_wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + c_wait_one;
                    if (w_wait_over) begin
                        r_rd_addr <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pin-facing controls decode the state directly so reset clears them at once.
    assign bus.sen     = (r_state == ST_SHIFT);
    assign bus.sclk_en = (r_state == ST_SHIFT);
    assign bus.sdi     = (r_state == ST_SHIFT) & bus.rd_data;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_FINISH);
    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_en   = r_wr_en;

endmodule

`default_nettype wire

// File: tb/tb_spi_bit_sequencer.sv
// ============================================================================
// Module   : tb_spi_bit_sequencer
// Brief    : Directed self-checking bench for spi_bit_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_bit_sequencer;

    localparam int ADDR_W = 14;
    localparam int WAIT_W = 16;
    localparam int REP_W  = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    spi_bit_sequencer_if #(.ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .REP_W(REP_W)) bus ();

    spi_bit_sequencer #(.ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .REP_W(REP_W)) dut (
        .spi_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read output memory, write-only input memory, SDO looped back.
    logic out_mem [0:(1<<ADDR_W)-1];
    logic in_mem  [0:(1<<ADDR_W)-1];
    logic [15:0] pat;

    always @(posedge clk) bus.rd_data <= out_mem[bus.rd_addr];
    always @(posedge clk) if (bus.wr_en) in_mem[bus.wr_addr] <= bus.wr_data;
    assign bus.sdo = bus.sdi;

    int cyc = 0, start_cyc, first_sen, last_sen, sen_cycles, bursts;
    int wr_cnt, done_cnt, done_cyc, busy_cnt, max_rd, lat_err;
    logic sen_prev, sdi_prev;
    bit sdi_q[$];
    int wr_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.start === 1'b1 && start_cyc < 0) start_cyc = cyc;
        if (bus.wr_en !== sen_prev) lat_err++;
        if (bus.wr_en === 1'b1 && bus.wr_data !== sdi_prev) lat_err++;
        if (bus.sen === 1'b1) begin
            sen_cycles++;
            if (first_sen < 0) first_sen = cyc;
            last_sen = cyc;
            if (!sen_prev) bursts++;
            sdi_q.push_back(bus.sdi);
        end
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            wr_q.push_back(int'(bus.wr_addr));
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.busy === 1'b1) begin
            busy_cnt++;
            if (int'(bus.rd_addr) > max_rd) max_rd = int'(bus.rd_addr);
        end
        sen_prev = bus.sen;
        sdi_prev = bus.sdi;
    end

    task automatic clear_mon();
        start_cyc = -1; first_sen = -1; last_sen = -1; sen_cycles = 0; bursts = 0;
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; max_rd = 0; lat_err = 0;
        sen_prev = 1'b0; sdi_prev = 1'b0;
        sdi_q.delete();
        wr_q.delete();
        for (int i = 0; i < 32; i++) in_mem[i] = 1'b0;
    endtask

    task automatic do_start(input int size, input int wt, input int rep);
        @(posedge clk); #1;
        bus.conf_size   = ADDR_W'(size);
        bus.conf_wait   = WAIT_W'(wt);
        bus.conf_repeat = REP_W'(rep);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no DONE within %0d cycles", name, max_cycles);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.conf_size = '0; bus.conf_wait = '0; bus.conf_repeat = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.wr_en, bus.sdi, bus.sen,
             bus.sclk_en, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%0d wr=%0d we=%b sen=%b busy=%b done=%b, required all 0",
                     bus.rd_addr, bus.wr_addr, bus.wr_en, bus.sen, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_mon();
    endtask

    task automatic test_single();
        logic [7:0] v, m;
        clear_mon();
        do_start(8, 0, 1);
        wait_done(40, "single");
        for (int i = 0; i < 8; i++) begin
            v[i] = (i < sdi_q.size()) ? sdi_q[i] : 1'bx;
            m[i] = in_mem[i];
        end
        checks++;
        if (first_sen - start_cyc != 2) begin
            errors++; $display("FAIL single_load_latency: got %0d required 2", first_sen - start_cyc);
        end
        checks++;
        if (sen_cycles != 8 || bursts != 1) begin
            errors++; $display("FAIL single_sen: got %0d cycles %0d bursts, required 8/1", sen_cycles, bursts);
        end
        checks++;
        if (v !== 8'hB2) begin
            errors++; $display("FAIL single_sdi_seq: got %b required 10110010", v);
        end
        checks++;
        if (wr_cnt != 8 || wr_q.size() != 8 || wr_q[0] != 0 || wr_q[7] != 7 || lat_err != 0) begin
            errors++; $display("FAIL single_writes: got %0d writes, latency errors %0d, required 8/0", wr_cnt, lat_err);
        end
        checks++;
        if (m !== 8'hB2) begin
            errors++; $display("FAIL single_in_mem: got %b required 10110010", m);
        end
        checks++;
        if (done_cnt != 1 || bus.busy !== 1'b0 || max_rd > 7) begin
            errors++; $display("FAIL single_done: got done=%0d busy=%b max_rd=%0d, required 1/0/<=7", done_cnt, bus.busy, max_rd);
        end
    endtask

    task automatic test_repeat_wait();
        clear_mon();
        do_start(4, 5, 3);
        wait_done(100, "repeat");
        checks++;
        if (bursts != 3 || sen_cycles != 12) begin
            errors++; $display("FAIL repeat_bursts: got %0d bursts %0d cycles, required 3/12", bursts, sen_cycles);
        end
        checks++;
        if (last_sen - first_sen + 1 != 24) begin
            errors++; $display("FAIL repeat_span: got %0d required 24", last_sen - first_sen + 1);
        end
        checks++;
        if (wr_cnt != 12 || done_cnt != 1 || lat_err != 0 || max_rd > 3) begin
            errors++; $display("FAIL repeat_writes: got wr=%0d done=%0d lat=%0d max_rd=%0d, required 12/1/0/<=3",
                               wr_cnt, done_cnt, lat_err, max_rd);
        end
    endtask

    task automatic test_stop();
        int n;
        clear_mon();
        do_start(3, 2, 0);
        n = 0;
        while (bursts < 2 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        bus.stop = 1'b1;
        wait_done(60, "stop");
        bus.stop = 1'b0;
        checks++;
        if (bursts != 2 || sen_cycles != 6 || wr_cnt != 6) begin
            errors++; $display("FAIL stop_complete: got %0d bursts %0d sen %0d wr, required 2/6/6", bursts, sen_cycles, wr_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_sen + 1) begin
            errors++; $display("FAIL stop_done: got done=%0d at +%0d, required 1 at +1", done_cnt, done_cyc - last_sen);
        end
    endtask

    task automatic test_zero_size();
        clear_mon();
        do_start(0, 0, 1);
        wait_done(10, "zero");
        checks++;
        if (sen_cycles != 0 || wr_cnt != 0) begin
            errors++; $display("FAIL zero_activity: got sen=%0d wr=%0d, required 0/0", sen_cycles, wr_cnt);
        end
        checks++;
        if (done_cyc - start_cyc != 1 || busy_cnt != 1 || done_cnt != 1) begin
            errors++; $display("FAIL zero_done: got delay=%0d busy=%0d done=%0d, required 1/1/1",
                               done_cyc - start_cyc, busy_cnt, done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] v;
        clear_mon();
        do_start(16, 0, 1);
        repeat (2) begin
            repeat (3) @(posedge clk);
            #1;
            bus.conf_size = ADDR_W'(5);
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        wait_done(60, "busy_start");
        for (int i = 0; i < 16; i++) v[i] = (i < sdi_q.size()) ? sdi_q[i] : 1'bx;
        checks++;
        if (sen_cycles != 16 || bursts != 1 || wr_cnt != 16 || done_cnt != 1) begin
            errors++; $display("FAIL busy_start_count: got sen=%0d bursts=%0d wr=%0d done=%0d, required 16/1/16/1",
                               sen_cycles, bursts, wr_cnt, done_cnt);
        end
        checks++;
        if (v !== pat) begin
            errors++; $display("FAIL busy_start_data: got %h required %h", v, pat);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [9:0] v;
        clear_mon();
        do_start(10, 0, 1);
        n = 0;
        while (sen_cycles < 6 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sen, bus.sclk_en, bus.wr_en, bus.busy} !== 4'b0000 || n >= 40) begin
            errors++; $display("FAIL reset_mid_async: got sen/sclk/we/busy=%b%b%b%b, required 0000",
                               bus.sen, bus.sclk_en, bus.wr_en, bus.busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.sen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle: got busy=%b sen=%b, required 0/0", bus.busy, bus.sen);
        end
        clear_mon();
        do_start(10, 0, 1);
        wait_done(40, "reset_rerun");
        for (int i = 0; i < 10; i++) v[i] = (i < sdi_q.size()) ? sdi_q[i] : 1'bx;
        checks++;
        if (sen_cycles != 10 || first_sen - start_cyc != 2 || wr_q.size() != 10 || wr_q[0] != 0) begin
            errors++; $display("FAIL reset_rerun_count: got sen=%0d lat=%0d wr=%0d, required 10/2/10",
                               sen_cycles, first_sen - start_cyc, wr_q.size());
        end
        checks++;
        if (v !== pat[9:0] || lat_err != 0) begin
            errors++; $display("FAIL reset_rerun_data: got %b lat=%0d required %b/0", v, lat_err, pat[9:0]);
        end
    endtask

    initial begin
        pat = 16'h6DB2;
        for (int i = 0; i < (1<<ADDR_W); i++) begin
            out_mem[i] = (i < 16) ? pat[i] : 1'b0;
            in_mem[i]  = 1'b0;
        end
        test_reset();
        test_single();
        test_repeat_wait();
        test_stop();
        test_zero_size();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
